// File: rtl/sr_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the SR synchroniser bank.
// sr_mode_t selects what a channel does when filtered S and R are both high.
package sr_pkg;

    typedef enum logic [1:0] {
        SR_SET_DOM,
        SR_RESET_DOM,
        SR_HOLD,
        SR_TOGGLE
    } sr_mode_t;

    localparam int SR_MAX_DEBOUNCE = 255;

    // Width of a counter that must hold 0..debounce, never narrower than 1 bit.
    function automatic int sr_cnt_width(input int debounce);
        int w;
        w = $clog2(debounce + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sr_sync_bank_if.sv
`timescale 1ns/1ps
// Bundles the per-channel request/status buses of sr_sync_bank.
// The master side drives S/R/clr_err; the slave side returns Q/Qbar/err.
interface sr_sync_bank_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] R;
    logic             clr_err;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qbar;
    logic [WIDTH-1:0] err;

    modport master (
        output S, R, clr_err,
        input  Q, Qbar, err
    );

    modport slave (
        input  S, R, clr_err,
        output Q, Qbar, err
    );
endinterface

// File: rtl/sr_sync_cell.sv
`timescale 1ns/1ps
// One SR channel: synchronise and debounce S and R, then update the SR register
// and its sticky illegal-condition flag.
module sr_sync_cell
    import sr_pkg::*;
#(
    parameter int       SYNC_STAGES = 2,
    parameter int       DEBOUNCE    = 0,
    parameter sr_mode_t MODE        = SR_RESET_DOM
) (
    input  logic CLK,
    input  logic nReset,
    input  logic i_s,
    input  logic i_r,
    input  logic i_clr_err,
    output logic o_q,
    output logic o_qbar,
    output logic o_err
);

    // Bit 1 carries S, bit 0 carries R, so w_filt reads as {fS, fR}.
    logic [1:0] w_raw;
    logic [1:0] w_synced;
    logic [1:0] w_filt;

    assign w_raw = {i_s, i_r};

    for (genvar k = 0; k < 2; k++) begin : g_in
        logic [SYNC_STAGES-1:0] r_sync;

        always_ff @(posedge CLK or negedge nReset) begin
            if (!nReset) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[k]};
            end
        end

        assign w_synced[k] = r_sync[SYNC_STAGES-1];

        if (DEBOUNCE == 0) begin : g_bypass
            assign w_filt[k] = w_synced[k];
        end else begin : g_debounce
            localparam int            CW = sr_cnt_width(DEBOUNCE);
            localparam logic [CW-1:0] TC = CW'(DEBOUNCE);

            logic [CW-1:0] r_cnt;
            logic [CW-1:0] w_cnt_inc;
            logic          r_filt;

            assign w_cnt_inc = r_cnt + 1'b1;

            // Any cycle where synced agrees with filtered restarts the count,
            // so pulses shorter than DEBOUNCE cycles never get through.
            always_ff @(posedge CLK or negedge nReset) begin
                if (!nReset) begin
                    r_cnt  <= '0;
                    r_filt <= 1'b0;
                end else if (w_synced[k] == r_filt) begin
                    r_cnt  <= '0;
                end else if (w_cnt_inc == TC) begin
                    r_filt <= w_synced[k];
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= w_cnt_inc;
                end
            end

            assign w_filt[k] = r_filt;
        end
    end

    logic r_q;
    logic r_qbar;
    logic r_err;
    logic w_q_nxt;
    logic w_illegal;

    assign w_illegal = &w_filt;

    always_comb begin
        w_q_nxt = r_q;
        case (w_filt)
            2'b10:   w_q_nxt = 1'b1;
            2'b01:   w_q_nxt = 1'b0;
            2'b11: begin
                case (MODE)
                    SR_SET_DOM:   w_q_nxt = 1'b1;
                    SR_RESET_DOM: w_q_nxt = 1'b0;
                    SR_TOGGLE:    w_q_nxt = ~r_q;
                    default:      w_q_nxt = r_q;
                endcase
            end
            default: w_q_nxt = r_q;
        endcase
    end

    // Qbar has its own flop so both outputs come straight from registers.
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            r_q    <= 1'b0;
            r_qbar <= 1'b1;
            r_err  <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_qbar <= ~w_q_nxt;
            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (i_clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_q    = r_q;
    assign o_qbar = r_qbar;
    assign o_err  = r_err;

endmodule

// File: rtl/sr_sync_bank.sv
`timescale 1ns/1ps
// Bank of WIDTH independent SR channels fed by asynchronous S/R requests.
// Reset release is assumed synchronous to CLK; no reset synchroniser lives here.
module sr_sync_bank
    import sr_pkg::*;
#(
    parameter int       WIDTH       = 4,
    parameter int       SYNC_STAGES = 2,
    parameter int       DEBOUNCE    = 0,
    parameter sr_mode_t MODE        = SR_RESET_DOM
) (
    input  logic             CLK,
    input  logic             nReset,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             clr_err,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic [WIDTH-1:0] err
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sr_sync_cell #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE),
            .MODE        (MODE)
        ) u_cell (
            .CLK       (CLK),
            .nReset    (nReset),
            .i_s       (S[i]),
            .i_r       (R[i]),
            .i_clr_err (clr_err),
            .o_q       (Q[i]),
            .o_qbar    (Qbar[i]),
            .o_err     (err[i])
        );
    end

endmodule

// File: doc/sr_sync_bank.md
SR_SYNC_BANK -- requirements
Module: sr_sync_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of independent SR channels (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving synchroniser flops per input (2..4).
REQ-003 The block SHALL have parameter DEBOUNCE, default 0, giving the stability cycles required before a filtered input changes (0 = filter bypassed, max 255).
REQ-004 The block SHALL have parameter MODE, type sr_mode_t, default SR_RESET_DOM, selecting the S=R=1 behaviour for all channels.
REQ-005 The block SHALL have port CLK, input, 1 bit, the single rising-edge clock.
REQ-006 The block SHALL have port nReset, input, 1 bit, reset that is asynchronous and active-low.
REQ-007 The block SHALL have port S, input, WIDTH bits, asynchronous per-channel set requests.
REQ-008 The block SHALL have port R, input, WIDTH bits, asynchronous per-channel reset requests.
REQ-009 The block SHALL have port clr_err, input, 1 bit, a synchronous clear of all error flags.
REQ-010 The block SHALL have port Q, output, WIDTH bits, the registered channel state.
REQ-011 The block SHALL have port Qbar, output, WIDTH bits, always equal to ~Q.
REQ-012 The block SHALL have port err, output, WIDTH bits, sticky per-channel illegal-condition flags.

Function
REQ-013 Each S and R bit SHALL pass through a SYNC_STAGES-deep flop chain, with the last stage giving the synced value.
REQ-014 With DEBOUNCE=0, the filtered value SHALL equal the synced value.
REQ-015 With DEBOUNCE>0, a per-input counter SHALL increment on each edge where synced differs from filtered, and SHALL clear to 0 on any edge where they are equal.
REQ-016 The filtered value SHALL take the synced value on the edge where the counter would reach DEBOUNCE, and the counter SHALL clear on that same edge.
REQ-017 Synced pulses shorter than DEBOUNCE cycles SHALL never reach the filtered value.
REQ-018 Per channel, the filtered input fS,fR = 00 SHALL hold Q, 10 SHALL set Q=1, and 01 SHALL clear Q=0, on the next rising edge.
REQ-019 For fS,fR = 11, SR_SET_DOM SHALL set Q=1, SR_RESET_DOM SHALL clear Q=0, SR_HOLD SHALL hold Q, and SR_TOGGLE SHALL invert Q on every edge the condition persists.
REQ-020 fS,fR = 11 on any edge SHALL set err[i]=1 on that edge, regardless of MODE.
REQ-021 err SHALL clear only on an edge with clr_err=1, and a simultaneous new 11 on channel i SHALL leave err[i]=1 (set wins).
REQ-022 Latency from an input change stable before edge 0 to its effect on Q SHALL be exactly L = SYNC_STAGES + DEBOUNCE + 1 edges.
REQ-023 Channels SHALL be fully independent, with no cross-channel interaction except the shared clr_err.
REQ-024 Q, Qbar and err SHALL be glitch-free register outputs, with Qbar driven from its own register or as the inverse of Q.

Reset
REQ-025 nReset=0 SHALL immediately, without a clock edge, force Q=0, Qbar=all ones, err=0, all synchroniser flops=0, all filtered values=0 and all counters=0.
REQ-026 While nReset=0, S, R and clr_err SHALL be ignored.
REQ-027 Reset asserted mid-debounce or mid-toggle SHALL discard all progress, and operation SHALL restart from the reset state after release.
REQ-028 nReset release SHALL be treated as synchronous to CLK by the integrator, and the block SHALL NOT contain a reset synchroniser.

Structure
REQ-029 Package sr_pkg SHALL define enum sr_mode_t {SR_SET_DOM, SR_RESET_DOM, SR_HOLD, SR_TOGGLE} and constant SR_MAX_DEBOUNCE=255.
REQ-030 One sub-module, sr_sync_cell, SHALL implement a single channel (two synchronisers, two debounce filters, SR register, err flag), instantiated WIDTH times via generate.
REQ-031 The debounce counter width SHALL be $clog2(DEBOUNCE+1), with a minimum of 1.

Verification
REQ-032 Bench SHALL use WIDTH=4, SYNC_STAGES=2, DEBOUNCE=3 (L=6) unless a scenario states otherwise.
REQ-033 Reset: drive nReset=0 with S=4'hF, R=0 -> within 1 ns Q=0, Qbar=4'hF, err=0, and values hold with no edges.
REQ-034 Latency: after reset release, drive S=4'b0001 held -> Q=4'b0001 exactly on the 6th edge, and Q=0 on edges 1-5.
REQ-035 Glitch reject: pulse R[0]=1 for 2 cycles after Q[0]=1 -> Q[0] stays 1; a 3-cycle pulse -> Q[0]=0 on the 6th edge after its start.
REQ-036 Illegal/mode: hold S=R=4'b0010 with MODE=SR_TOGGLE and DEBOUNCE=0 -> Q[1] alternates 1,0,1 on successive edges from edge 3, err[1]=1 from edge 3, and repeating under each other MODE gives 1, 0 or held.
REQ-037 Err clear: with err=4'b0010 and 11 persisting on channel 1, pulse clr_err for 1 cycle -> err[1] stays 1; remove 11, wait L, then pulse clr_err -> err=0 next edge.
REQ-038 Mid-op reset: assert nReset during the debounce count, then release -> Q=0 and the full L latency is observed again.
